// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receiver (optional parity, selectable bit order) feeding a
//            first-word-fall-through receive FIFO with error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int MSB_FIRST    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   C_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   C_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BW-1:0]   C_NBITS = BW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] C_DEPTH = CNTW'(FIFO_DEPTH);
    localparam logic            C_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bitcnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_pfault;
    logic                  r_push;
    logic                  r_frame_err;
    logic                  r_parity_err;
    logic                  r_overrun;

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNTW-1:0]       r_count;

    logic                  w_rxs;
    logic                  w_par_exp;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_wr;

    assign w_rxs     = r_sync2;
    assign w_par_exp = (^r_shift) ^ C_ODD;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver FSM: bit timing, deserialisation, parity/stop checks, push request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_pfault     <= 1'b0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                            r_pfault <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt    <= '0;
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (MSB_FIRST != 0) begin
                            r_shift <= {r_shift[DATA_BITS-2:0], w_rxs};
                        end else begin
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_bitcnt == C_NBITS) begin
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt    <= '0;
                        r_pfault <= (w_rxs != w_par_exp);
                        r_state  <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            if (r_pfault) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_push <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_en && !w_empty;
    assign w_wr    = r_push && (!w_full || w_pop);

    // FIFO pointers, occupancy and overrun detection (a pop frees room for a same-cycle push).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push && w_full && !w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign rx_busy    = (r_state != S_IDLE);
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
